// File: rtl/param_shift_reg.sv
// param_shift_reg: WIDTH-bit universal shift register with word-shift counter; define PARAM_SHIFT_REG_ROTATE_EN to add rotate input rot
module param_shift_reg #(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
`ifdef PARAM_SHIFT_REG_ROTATE_EN
    input  logic             rot,
`endif
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             frame_done
);
    logic fill_r, fill_l, shift, wrap;
`ifdef PARAM_SHIFT_REG_ROTATE_EN
    assign fill_r = rot ? q[WIDTH-1] : sin_r;
    assign fill_l = rot ? q[0] : sin_l;
`else
    assign fill_r = sin_r;
    assign fill_l = sin_l;
`endif
    assign shift  = en && (mode == 2'b01 || mode == 2'b10);
    assign wrap   = shift_cnt == CNT_W'(WIDTH - 1);
    assign sout_l = q[WIDTH-1];
    assign sout_r = q[0];
    always_ff @(posedge clk) begin
        if (rst) begin
            q          <= RESET_VAL;
            shift_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= shift && wrap;
            if (en && mode == 2'b11) begin
                q         <= d;
                shift_cnt <= '0;
            end else if (shift) begin
                q         <= mode[0] ? {q[WIDTH-2:0], fill_r} : {fill_l, q[WIDTH-1:1]};
                shift_cnt <= wrap ? '0 : shift_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_param_shift_reg.sv
// tb_param_shift_reg: table-driven directed checks of param_shift_reg at WIDTH=8, RESET_VAL=8'hA5
module tb_param_shift_reg;
    logic clk = 1'b0, rst = 1'b1, en = 1'b0, sin_r = 1'b0, sin_l = 1'b0, rot = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] d = 8'h00, q;
    logic sout_l, sout_r, frame_done;
    logic [2:0] shift_cnt;
    int passed = 0, total = 0;

    typedef struct {
        logic r, e;
        logic [1:0] m;
        logic sr, sl;
        logic [7:0] dd, eq;
        logic [2:0] ec;
        logic ef;
    } vec_t;
    vec_t v[$];

    param_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
`ifdef PARAM_SHIFT_REG_ROTATE_EN
        .rot(rot),
`endif
        .d(d), .q(q), .sout_l(sout_l), .sout_r(sout_r),
        .shift_cnt(shift_cnt), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step(input logic r, input logic e, input logic [1:0] m,
                        input logic sr, input logic sl, input logic [7:0] dd);
        rst = r; en = e; mode = m; sin_r = sr; sin_l = sl; d = dd;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [7:0] eq, input logic [2:0] ec, input logic ef);
        check({tag, " q"}, 32'(q), 32'(eq));
        check({tag, " sout_l"}, 32'(sout_l), 32'(eq[7]));
        check({tag, " sout_r"}, 32'(sout_r), 32'(eq[0]));
        check({tag, " shift_cnt"}, 32'(shift_cnt), 32'(ec));
        check({tag, " frame_done"}, 32'(frame_done), 32'(ef));
    endtask

    initial begin
        // reset overrides a simultaneous load
        v.push_back('{1, 1, 2'b11, 0, 0, 8'hFF, 8'hA5, 3'd0, 0});
        v.push_back('{1, 1, 2'b11, 0, 0, 8'hFF, 8'hA5, 3'd0, 0});
        v.push_back('{0, 1, 2'b11, 0, 0, 8'h81, 8'h81, 3'd0, 0});
        v.push_back('{0, 1, 2'b01, 0, 0, 8'h00, 8'h02, 3'd1, 0});
        v.push_back('{0, 1, 2'b01, 0, 0, 8'h00, 8'h04, 3'd2, 0});
        v.push_back('{0, 1, 2'b01, 0, 0, 8'h00, 8'h08, 3'd3, 0});
        v.push_back('{0, 1, 2'b01, 0, 0, 8'h00, 8'h10, 3'd4, 0});
        v.push_back('{0, 1, 2'b01, 0, 0, 8'h00, 8'h20, 3'd5, 0});
        v.push_back('{0, 1, 2'b01, 0, 0, 8'h00, 8'h40, 3'd6, 0});
        v.push_back('{0, 1, 2'b01, 0, 0, 8'h00, 8'h80, 3'd7, 0});
        v.push_back('{0, 1, 2'b01, 0, 0, 8'h00, 8'h00, 3'd0, 1});
        v.push_back('{0, 1, 2'b00, 0, 0, 8'h00, 8'h00, 3'd0, 0});
        // right shifts fill 1,0,1,1,0,0,1,0 from the top
        v.push_back('{0, 1, 2'b10, 0, 1, 8'h00, 8'h80, 3'd1, 0});
        v.push_back('{0, 1, 2'b10, 0, 0, 8'h00, 8'h40, 3'd2, 0});
        v.push_back('{0, 1, 2'b10, 0, 1, 8'h00, 8'hA0, 3'd3, 0});
        v.push_back('{0, 1, 2'b10, 0, 1, 8'h00, 8'hD0, 3'd4, 0});
        v.push_back('{0, 1, 2'b10, 0, 0, 8'h00, 8'h68, 3'd5, 0});
        v.push_back('{0, 1, 2'b10, 0, 0, 8'h00, 8'h34, 3'd6, 0});
        v.push_back('{0, 1, 2'b10, 0, 1, 8'h00, 8'h9A, 3'd7, 0});
        v.push_back('{0, 1, 2'b10, 0, 0, 8'h00, 8'h4D, 3'd0, 1});
        // enable gating mid-frame
        v.push_back('{0, 1, 2'b01, 1, 0, 8'h00, 8'h9B, 3'd1, 0});
        v.push_back('{0, 1, 2'b01, 1, 0, 8'h00, 8'h37, 3'd2, 0});
        v.push_back('{0, 1, 2'b01, 1, 0, 8'h00, 8'h6F, 3'd3, 0});
        for (int i = 0; i < 4; i++) v.push_back('{0, 0, 2'b01, 1, 0, 8'h00, 8'h6F, 3'd3, 0});
        v.push_back('{0, 1, 2'b01, 0, 0, 8'h00, 8'hDE, 3'd4, 0});
        v.push_back('{0, 1, 2'b01, 0, 0, 8'h00, 8'hBC, 3'd5, 0});
        v.push_back('{0, 1, 2'b01, 0, 0, 8'h00, 8'h78, 3'd6, 0});
        v.push_back('{0, 1, 2'b01, 0, 0, 8'h00, 8'hF0, 3'd7, 0});
        v.push_back('{0, 1, 2'b01, 0, 0, 8'h00, 8'hE0, 3'd0, 1});
        v.push_back('{0, 1, 2'b11, 0, 0, 8'h5A, 8'h5A, 3'd0, 0});

        for (int i = 0; i < v.size(); i++) begin
            step(v[i].r, v[i].e, v[i].m, v[i].sr, v[i].sl, v[i].dd);
            check_all($sformatf("vec%0d", i), v[i].eq, v[i].ec, v[i].ef);
        end

        // reset mid-frame aborts without a pulse
        step(0, 1, 2'b11, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) step(0, 1, 2'b01, 1, 0, 8'h00);
        check_all("pre-rst", 8'h1F, 3'd5, 0);
        step(1, 1, 2'b01, 1, 0, 8'h00);
        check_all("mid-rst", 8'hA5, 3'd0, 0);
        step(0, 1, 2'b01, 0, 0, 8'h00);
        step(0, 1, 2'b01, 0, 0, 8'h00);
        step(0, 1, 2'b01, 0, 0, 8'h00);
        check_all("post-rst", 8'h28, 3'd3, 0);

        // load mid-frame restarts the count
        step(0, 1, 2'b11, 0, 0, 8'h00);
        for (int i = 0; i < 6; i++) step(0, 1, 2'b01, 0, 0, 8'h00);
        check("pre-load cnt", 32'(shift_cnt), 32'd6);
        step(0, 1, 2'b11, 0, 0, 8'h3C);
        check_all("mid-load", 8'h3C, 3'd0, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 2'b01, 0, 0, 8'h00);
            check($sformatf("reload shift%0d fd", i), 32'(frame_done), 32'(i == 7));
        end
        check("reload final q", 32'(q), 32'h00);

`ifdef PARAM_SHIFT_REG_ROTATE_EN
        step(0, 1, 2'b11, 0, 0, 8'h81);
        rot = 1'b1;
        step(0, 1, 2'b01, 0, 0, 8'h00);
        check("rotl q", 32'(q), 32'h03);
        step(0, 1, 2'b10, 0, 0, 8'h00);
        check("rotr q", 32'(q), 32'h81);
        step(0, 1, 2'b11, 0, 0, 8'h81);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 2'b01, 0, 0, 8'h00);
            check($sformatf("rot%0d fd", i), 32'(frame_done), 32'(i == 7));
        end
        check("rot8 q", 32'(q), 32'h81);
        rot = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
